// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Widths here bound the largest requester count the pick function supports.
package arbiter_pkg;

  localparam int MAX_N     = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid_vec scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] valid_vec,
                                    input int unsigned      ptr,
                                    input int unsigned      n);
    pick_t       res;
    int unsigned i;
    res = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      i = ptr + k;
      if (i >= n) i = i - n;
      if (k < n && !res.found && valid_vec[i[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = i[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbiter_out_buffer.sv
// Two-entry output FIFO holding {data, src}; the head is driven straight from storage.
// state     | meaning
// BUF_EMPTY | no beat held, out_valid low
// BUF_ONE   | one beat held, push still allowed
// BUF_FULL  | two beats held, push blocked
module arbiter_out_buffer
  import arbiter_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int IDX_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic [IDX_W-1:0]  push_src,
  output logic              full,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [IDX_W-1:0]  out_src,
  input  logic              out_ready
);

  buf_state_e        r_state, w_state_nxt;
  logic [DWIDTH-1:0] r_data [2];
  logic [IDX_W-1:0]  r_src  [2];
  logic              r_wr_ptr, r_rd_ptr;
  logic              w_do_push, w_do_pop;

  assign full      = (r_state == BUF_FULL);
  assign out_valid = (r_state != BUF_EMPTY);
  assign out_data  = r_data[r_rd_ptr];
  assign out_src   = r_src[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUF_EMPTY: if (w_do_push) w_state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (w_do_push && !w_do_pop)      w_state_nxt = BUF_FULL;
        else if (!w_do_push && w_do_pop) w_state_nxt = BUF_EMPTY;
      end
      BUF_FULL:  if (w_do_pop) w_state_nxt = BUF_ONE;
      default:   w_state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= BUF_EMPTY;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_src[0]  <= '0;
      r_src[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_do_push) begin
        r_data[r_wr_ptr] <= push_data;
        r_src[r_wr_ptr]  <= push_src;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

endmodule

// File: rtl/arbiter_rr_burst_n.sv
// N-to-1 round-robin merge with per-requester burst allowance; in_ready never
// looks at out_ready, so the downstream ready path stops at the output buffer.
module arbiter_rr_burst_n
  import arbiter_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int N      = 2,
  parameter int BURST  = 1,
  parameter int IDX_W  = idx_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid [N],
  input  logic [DWIDTH-1:0] in_data  [N],
  output logic              in_ready [N],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [IDX_W-1:0]  out_src,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(BURST + 1);

  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [MAX_N-1:0]  w_valid_vec;
  pick_t             w_pick;
  logic [IDX_W-1:0]  w_win;
  logic              w_full, w_push;
  logic [DWIDTH-1:0] w_push_data;
  logic              w_unused_pick_hi;

  always_comb begin
    w_valid_vec = '0;
    for (int i = 0; i < N; i++) w_valid_vec[i] = in_valid[i];
    w_pick = rr_pick(w_valid_vec, 32'(r_ptr), 32'(N));
  end

  assign w_win            = w_pick.idx[IDX_W-1:0];
  assign w_unused_pick_hi = |(w_pick.idx >> IDX_W);
  // rst gates the grant so nothing is offered while reset is held
  assign w_push           = rst & w_pick.found & ~w_full;
  assign w_push_data      = in_data[w_win];

  always_comb begin
    for (int i = 0; i < N; i++) in_ready[i] = w_push && (w_win == IDX_W'(i));
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_cnt_inc = (w_win == r_ptr) ? r_cnt + 1'b1 : CNT_W'(1);
    if (w_push) begin
      if (w_cnt_inc == CNT_W'(BURST)) begin
        w_ptr_nxt = (w_win == IDX_W'(N - 1)) ? '0 : w_win + 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_ptr_nxt = w_win;
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  arbiter_out_buffer #(
    .DWIDTH (DWIDTH),
    .IDX_W  (IDX_W)
  ) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .push_src  (w_win),
    .full      (w_full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_arbiter_rr_burst_n.sv
// Directed bench for two arbiter configurations (N=4/BURST=1 and N=2/BURST=2)
// with a reference model and per-instance scoreboard queues.
module tb_arbiter_rr_burst_n;

  logic        clk;
  logic        rst;

  logic        v4 [4];
  logic [15:0] d4 [4];
  logic        r4 [4];
  logic        ov4;
  logic [15:0] od4;
  logic [1:0]  os4;
  logic        ordy4;

  logic        v2 [2];
  logic [15:0] d2 [2];
  logic        r2 [2];
  logic        ov2;
  logic [15:0] od2;
  logic [0:0]  os2;
  logic        ordy2;

  int n_assert = 0;
  int n_fail   = 0;

  int mptr   [2];
  int mcnt   [2];
  int mcount [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int acc0 [$];
  int acc1 [$];

  arbiter_rr_burst_n #(.DWIDTH(16), .N(4), .BURST(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
    .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(ordy4)
  );

  arbiter_rr_burst_n #(.DWIDTH(16), .N(2), .BURST(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(r2),
    .out_valid(ov2), .out_data(od2), .out_src(os2), .out_ready(ordy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k);
    int          n, burst, win, c;
    logic [3:0]  v, rdy;
    logic [15:0] d [4];
    logic        ov, ordy, full_m, push_m, pop_m;
    logic [15:0] od;
    logic [1:0]  os;
    logic [31:0] head, entry;
    n = (k == 0) ? 4 : 2;
    burst = (k == 0) ? 1 : 2;
    v = '0;
    rdy = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    if (k == 0) begin
      for (int i = 0; i < 4; i++) begin v[i] = v4[i]; rdy[i] = r4[i]; d[i] = d4[i]; end
      ov = ov4; od = od4; os = os4; ordy = ordy4;
    end else begin
      for (int i = 0; i < 2; i++) begin v[i] = v2[i]; rdy[i] = r2[i]; d[i] = d2[i]; end
      ov = ov2; od = od2; os = {1'b0, os2}; ordy = ordy2;
    end
    win = -1;
    for (int j = 0; j < n; j++) begin
      int idx;
      idx = (mptr[k] + j) % n;
      if (win < 0 && v[idx]) win = idx;
    end
    full_m = (mcount[k] == 2);
    for (int i = 0; i < n; i++)
      chk($sformatf("dut%0d in_ready[%0d]", k, i), rdy[i], (rst && win == i && !full_m));
    chk($sformatf("dut%0d out_valid", k), ov, (rst && mcount[k] != 0));
    if (!rst) begin
      mptr[k] = 0; mcnt[k] = 0; mcount[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    pop_m = (mcount[k] != 0) && ordy;
    if (mcount[k] != 0) begin
      head = (k == 0) ? q0[0] : q1[0];
      chk($sformatf("dut%0d out_data", k), od, head[15:0]);
      chk($sformatf("dut%0d out_src", k), os, head[17:16]);
      if (pop_m) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    push_m = (win >= 0) && !full_m;
    if (push_m) begin
      entry = {14'b0, 2'(win), d[win]};
      if (k == 0) begin q0.push_back(entry); acc0.push_back(win); end
      else begin q1.push_back(entry); acc1.push_back(win); end
      c = (win == mptr[k]) ? mcnt[k] + 1 : 1;
      if (c == burst) begin mptr[k] = (win + 1) % n; mcnt[k] = 0; end
      else begin mptr[k] = win; mcnt[k] = c; end
    end
    mcount[k] = mcount[k] + int'(push_m) - int'(pop_m);
  endtask

  task automatic step();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) v4[i] = 1'b0;
    for (int i = 0; i < 2; i++) v2[i] = 1'b0;
    ordy4 = 1'b1;
    ordy2 = 1'b1;
  endtask

  initial begin
    int exp_rot [8];
    int exp_bur [8];
    exp_rot = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_bur = '{0, 0, 1, 1, 0, 0, 1, 1};
    for (int k = 0; k < 2; k++) begin mptr[k] = 0; mcnt[k] = 0; mcount[k] = 0; end
    rst = 1'b1;
    idle_all();
    for (int i = 0; i < 4; i++) d4[i] = 16'h0;
    for (int i = 0; i < 2; i++) d2[i] = 16'h0;
    #2 rst = 1'b0;

    // reset with random requests
    @(negedge clk);
    for (int i = 0; i < 4; i++) v4[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 2; i++) v2[i] = 1'($urandom_range(0, 1));
    step();
    step();
    chk("rst out_data4", od4, 16'h0);
    chk("rst out_src4", os4, 2'd0);
    chk("rst out_data2", od2, 16'h0);
    chk("rst out_src2", os2, 1'b0);
    idle_all();
    rst = 1'b1;
    step();
    chk("rel out_data4", od4, 16'h0);
    chk("rel out_src4", os4, 2'd0);
    chk("rel out_valid2", ov2, 1'b0);

    // rotation on dut4, burst on dut2, concurrently
    acc0.delete(); acc1.delete();
    for (int i = 0; i < 4; i++) begin v4[i] = 1'b1; d4[i] = 16'hA0 + 16'(i); end
    for (int i = 0; i < 2; i++) begin v2[i] = 1'b1; d2[i] = 16'hB0 + 16'(i); end
    for (int s = 0; s < 8; s++) step();
    idle_all();
    for (int s = 0; s < 3; s++) step();
    chk("rot accept count", acc0.size(), 8);
    chk("burst accept count", acc1.size(), 8);
    for (int i = 0; i < 8 && i < acc0.size(); i++) chk($sformatf("rot order[%0d]", i), acc0[i], exp_rot[i]);
    for (int i = 0; i < 8 && i < acc1.size(); i++) chk($sformatf("burst order[%0d]", i), acc1[i], exp_bur[i]);

    // skip and wrap
    acc0.delete();
    v4[3] = 1'b1; d4[3] = 16'hC3;
    step();
    v4[1] = 1'b1; d4[1] = 16'hC1;
    step();
    idle_all();
    for (int s = 0; s < 3; s++) step();
    chk("skip accept count", acc0.size(), 2);
    if (acc0.size() == 2) begin
      chk("skip grant", acc0[0], 3);
      chk("wrap grant", acc0[1], 1);
    end

    // backpressure
    acc0.delete();
    ordy4 = 1'b0;
    v4[0] = 1'b1; d4[0] = 16'd11;
    step();
    d4[0] = 16'd22;
    step();
    d4[0] = 16'd33;
    step();
    chk("bp in_ready0 low", r4[0], 1'b0);
    chk("bp head held", od4, 16'd11);
    step();
    ordy4 = 1'b1;
    step();
    step();
    v4[0] = 1'b0;
    step();
    step();
    chk("bp accept count", acc0.size(), 3);
    chk("bp scoreboard drained", q0.size(), 0);

    // reset mid-operation with a full buffer
    ordy4 = 1'b0;
    v4[2] = 1'b1; d4[2] = 16'h55;
    step();
    step();
    step();
    chk("pre-rst out_valid", ov4, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid rst out_valid", ov4, 1'b0);
    chk("mid rst in_ready2", r4[2], 1'b0);
    @(negedge clk);
    step();
    rst = 1'b1;
    acc0.delete();
    v4[2] = 1'b0; v4[1] = 1'b1; v4[3] = 1'b1;
    d4[1] = 16'h61; d4[3] = 16'h63;
    ordy4 = 1'b1;
    step();
    idle_all();
    for (int s = 0; s < 3; s++) step();
    chk("post-rst first grant", (acc0.size() > 0) ? acc0[0] : -1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
